// File: rtl/symbol_tx_scheduler.sv
// rtl/symbol_tx_scheduler.sv - symbol FIFO and waveform ROM sequencer for the TX sample stream
// Optional preamble generation is enabled by defining SYMTX_PREAMBLE_EN.
module symbol_tx_scheduler #(
  parameter int SAMPLES_PER_SYM = 16,
  parameter int FIFO_DEPTH      = 4,
  parameter int PREAMBLE_LEN    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sym_valid,
  input  logic [1:0]        sym_data,
  output logic              sym_ready,
  input  logic signed [9:0] sample_in0,
  input  logic signed [9:0] sample_in1,
  input  logic signed [9:0] sample_in2,
  input  logic signed [9:0] sample_in3,
  output logic [3:0]        phase,
  output logic [1:0]        sym_sel,
  output logic signed [9:0] tx_out,
  output logic              tx_valid,
  output logic              busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [3:0]  LAST_PH  = 4'(SAMPLES_PER_SYM - 1);
  localparam int PW = $clog2(PREAMBLE_LEN + 1);

  if (SAMPLES_PER_SYM < 2 || SAMPLES_PER_SYM > 16 || FIFO_DEPTH < 2 || PREAMBLE_LEN < 1) begin : g_param_check
    $error("symbol_tx_scheduler: unsupported parameter set");
  end

`ifdef SYMTX_PREAMBLE_EN
  typedef enum logic [1:0] {IDLE, RUN, PRE} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

  state_t          state, state_next;
  logic [1:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic [1:0]      head;
  logic            push, pop;
  logic            emit, sel_load;
  logic [1:0]      sel_value;
  logic signed [9:0] sample_sel;

  assign sym_ready = (count != FULL_CNT);
  assign push      = sym_valid && sym_ready;
  assign head      = mem[rd_ptr];
  assign busy      = (state != IDLE) || (count != '0);

  always_comb begin
    case (sym_sel)
      2'd0:    sample_sel = sample_in0;
      2'd1:    sample_sel = sample_in1;
      2'd2:    sample_sel = sample_in2;
      default: sample_sel = sample_in3;
    endcase
  end

`ifdef SYMTX_PREAMBLE_EN
  logic [PW-1:0] pre_cnt, pre_cnt_next;
`endif

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    emit       = 1'b0;
    sel_load   = 1'b0;
    sel_value  = sym_sel;
`ifdef SYMTX_PREAMBLE_EN
    pre_cnt_next = pre_cnt;
`endif
    case (state)
      IDLE: begin
        if (count != '0) begin
          sel_load = 1'b1;
`ifdef SYMTX_PREAMBLE_EN
          // FIFO data waits until the preamble has gone out
          sel_value    = 2'd0;
          pre_cnt_next = '0;
          state_next   = PRE;
`else
          pop        = 1'b1;
          sel_value  = head;
          state_next = RUN;
`endif
        end
      end
      RUN: begin
        emit = 1'b1;
        if (phase == LAST_PH) begin
          if (count != '0) begin
            pop       = 1'b1;
            sel_load  = 1'b1;
            sel_value = head;
          end else begin
            state_next = IDLE;
          end
        end
      end
`ifdef SYMTX_PREAMBLE_EN
      PRE: begin
        emit = 1'b1;
        if (phase == LAST_PH) begin
          sel_load = 1'b1;
          if (pre_cnt == PW'(PREAMBLE_LEN - 1)) begin
            pop        = 1'b1;
            sel_value  = head;
            state_next = RUN;
          end else begin
            sel_value    = (sym_sel == 2'd0) ? 2'd3 : 2'd0;
            pre_cnt_next = pre_cnt + 1'b1;
          end
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

`ifdef SYMTX_PREAMBLE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pre_cnt <= '0;
    else        pre_cnt <= pre_cnt_next;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase    <= '0;
      sym_sel  <= '0;
      tx_out   <= '0;
      tx_valid <= 1'b0;
    end else begin
      if (emit) begin
        tx_out   <= sample_sel;
        tx_valid <= 1'b1;
        phase    <= (phase == LAST_PH) ? 4'd0 : phase + 4'd1;
      end else begin
        tx_out   <= '0;
        tx_valid <= 1'b0;
        phase    <= '0;
      end
      if (sel_load) sym_sel <= sel_value;
    end
  end

  // Pop is only ever requested with count != 0, so count cannot underflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sym_data;
  end

endmodule

// File: tb/tb_symbol_tx_scheduler.sv
// tb/tb_symbol_tx_scheduler.sv - scoreboard bench for symbol_tx_scheduler
module tb_symbol_tx_scheduler;

`ifdef SYMTX_PREAMBLE_EN
  localparam int PRE_OFF = 64;
`else
  localparam int PRE_OFF = 0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sym_valid = 1'b0;
  logic [1:0]        sym_data = 2'd0;
  logic              sym_ready;
  logic signed [9:0] sample_in0, sample_in1, sample_in2, sample_in3;
  logic [3:0]        phase;
  logic [1:0]        sym_sel;
  logic signed [9:0] tx_out;
  logic              tx_valid;
  logic              busy;

  int cos_t [16] = '{100, 54, 0, -54, -100, -131, -141, -131, -100, -54, 0, 54, 100, 131, 141, 131};

  int checks = 0;
  int errors = 0;
  logic signed [9:0] sb [$];
  int   run_len = 0;
  int   last_run = 0;
  logic prev_valid = 1'b0;
  logic [1:0] prev_sel = 2'd0;

  always #5 clk = ~clk;

  function automatic logic signed [9:0] rom_val(input int s, input int k);
    int v;
    case (s)
      0:       v = cos_t[(k + 10) % 16];
      1:       v = -cos_t[(k + 10) % 16];
      2:       v = cos_t[k];
      default: v = -cos_t[k];
    endcase
    return 10'(v);
  endfunction

  assign sample_in0 = rom_val(0, int'(phase));
  assign sample_in1 = rom_val(1, int'(phase));
  assign sample_in2 = rom_val(2, int'(phase));
  assign sample_in3 = rom_val(3, int'(phase));

  symbol_tx_scheduler dut (
    .clk(clk), .rst_n(rst_n), .sym_valid(sym_valid), .sym_data(sym_data), .sym_ready(sym_ready),
    .sample_in0(sample_in0), .sample_in1(sample_in1), .sample_in2(sample_in2), .sample_in3(sample_in3),
    .phase(phase), .sym_sel(sym_sel), .tx_out(tx_out), .tx_valid(tx_valid), .busy(busy)
  );

  task automatic tick;
    logic signed [9:0] exp_s;
    @(negedge clk);
    if (rst_n) begin
      if (tx_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_extra: tx_out=%0d but no sample expected", tx_out);
        end else begin
          exp_s = sb.pop_front();
          if (tx_out !== exp_s) begin
            errors++;
            $display("FAIL sb_sample: tx_out=%0d expected %0d", tx_out, exp_s);
          end
        end
        run_len++;
      end else if (prev_valid) begin
        last_run = run_len;
        run_len  = 0;
      end
      if (sym_sel !== prev_sel) begin
        checks++;
        if (phase !== 4'd0) begin
          errors++;
          $display("FAIL sel_change: sym_sel changed at phase=%0d expected 0", phase);
        end
      end
      prev_sel   = sym_sel;
      prev_valid = tx_valid;
    end
  endtask

  task automatic expect_sym(input int s);
    for (int k = 0; k < 16; k++) sb.push_back(rom_val(s, k));
  endtask

  task automatic expect_start(input int s);
`ifdef SYMTX_PREAMBLE_EN
    for (int i = 0; i < 4; i++) expect_sym((i % 2) ? 3 : 0);
`endif
    expect_sym(s);
  endtask

  task automatic push(input logic [1:0] s, input bit from_idle, output int waited);
    waited    = 0;
    sym_valid = 1'b1;
    sym_data  = s;
    while (!sym_ready && waited < 300) begin
      tick();
      waited++;
    end
    checks++;
    if (!sym_ready) begin
      errors++;
      $display("FAIL push_timeout: sym_ready=%0b expected 1", sym_ready);
    end else if (from_idle) begin
      expect_start(s);
    end else begin
      expect_sym(s);
    end
    tick();
    sym_valid = 1'b0;
  endtask

  task automatic wait_idle;
    int n = 0;
    tick();
    while ((busy || tx_valid) && n < 3000) begin
      tick();
      n++;
    end
    checks++;
    if (busy || tx_valid) begin
      errors++;
      $display("FAIL idle_timeout: busy=%0b tx_valid=%0b expected 0", busy, tx_valid);
    end
  endtask

  task automatic test_reset_state;
    checks++;
    if (tx_out !== 10'sd0 || tx_valid !== 1'b0 || phase !== 4'd0 || sym_sel !== 2'd0 ||
        busy !== 1'b0 || sym_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: tx_out=%0d tx_valid=%0b phase=%0d sym_sel=%0d busy=%0b ready=%0b expected 0,0,0,0,0,1",
               tx_out, tx_valid, phase, sym_sel, busy, sym_ready);
    end
  endtask

  task automatic test_single;
    int w;
    push(2'd2, 1'b1, w);
    for (int k = 1; k <= 18 + PRE_OFF; k++) begin
      tick();
      if (k == 2 + PRE_OFF || k == 6 + PRE_OFF || k == 8 + PRE_OFF || k == 17 + PRE_OFF) begin
        int e;
        e = (k == 2 + PRE_OFF) ? 100 : (k == 6 + PRE_OFF) ? -100 : (k == 8 + PRE_OFF) ? -141 : 131;
        checks++;
        if (tx_out !== 10'(e) || tx_valid !== 1'b1) begin
          errors++;
          $display("FAIL single_t%0d: tx_out=%0d valid=%0b expected %0d valid=1", k - PRE_OFF, tx_out, tx_valid, e);
        end
      end
      if (k == 18 + PRE_OFF) begin
        checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL single_end: tx_valid=%0b busy=%0b expected 0 0", tx_valid, busy);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    int w;
    push(2'd2, 1'b1, w);
    push(2'd1, 1'b0, w);
    push(2'd3, 1'b0, w);
    push(2'd0, 1'b0, w);
    wait_idle();
    checks++;
    if (last_run !== 64 + PRE_OFF) begin
      errors++;
      $display("FAIL b2b_run: contiguous valid samples=%0d expected %0d", last_run, 64 + PRE_OFF);
    end
  endtask

  task automatic test_flow_control;
    int w;
    push(2'd0, 1'b1, w);
    push(2'd1, 1'b0, w);
    push(2'd2, 1'b0, w);
    push(2'd3, 1'b0, w);
    push(2'd1, 1'b0, w);
    checks++;
    if (sym_ready !== 1'b0) begin
      errors++;
      $display("FAIL fc_full: sym_ready=%0b expected 0", sym_ready);
    end
    push(2'd2, 1'b0, w);
    checks++;
    if (w == 0) begin
      errors++;
      $display("FAIL fc_stall: held symbol waited %0d cycles expected >0", w);
    end
    wait_idle();
  endtask

  task automatic test_simultaneous;
    int w;
    int n = 0;
    push(2'd1, 1'b1, w);
    push(2'd2, 1'b0, w);
    while (!(phase == 4'd15 && sym_sel == 2'd1 && tx_valid) && n < 300) begin
      tick();
      n++;
    end
    push(2'd3, 1'b0, w);
    checks++;
    if (sym_sel !== 2'd2 || phase !== 4'd0) begin
      errors++;
      $display("FAIL simul_wrap: sym_sel=%0d phase=%0d expected 2 0", sym_sel, phase);
    end
    for (int i = 0; i < 15; i++) tick();
    checks++;
    if (sym_sel !== 2'd2 || phase !== 4'd15) begin
      errors++;
      $display("FAIL simul_hold: sym_sel=%0d phase=%0d expected 2 15", sym_sel, phase);
    end
    tick();
    checks++;
    if (sym_sel !== 2'd3) begin
      errors++;
      $display("FAIL simul_next: sym_sel=%0d expected 3", sym_sel);
    end
    wait_idle();
  endtask

`ifdef SYMTX_PREAMBLE_EN
  task automatic test_preamble;
    int w;
    int n = 0;
    int seq [$];
    int exp_seq [5] = '{0, 3, 0, 3, 1};
    push(2'd1, 1'b1, w);
    while ((busy || tx_valid) && n < 300) begin
      tick();
      if (tx_valid && phase == 4'd1) seq.push_back(int'(sym_sel));
      n++;
    end
    checks++;
    if (seq.size() != 5) begin
      errors++;
      $display("FAIL pre_len: symbols seen=%0d expected 5", seq.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (seq[i] != exp_seq[i]) begin
          errors++;
          $display("FAIL pre_sym%0d: sym_sel=%0d expected %0d", i, seq[i], exp_seq[i]);
        end
      end
    end
  endtask
`endif

  task automatic test_reset;
    int w;
    int n = 0;
    push(2'd3, 1'b1, w);
    while (!(phase == 4'd7 && tx_valid) && n < 300) begin
      tick();
      n++;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (tx_out !== 10'sd0 || tx_valid !== 1'b0 || phase !== 4'd0 || sym_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: tx_out=%0d tx_valid=%0b phase=%0d ready=%0b busy=%0b expected 0,0,0,1,0",
               tx_out, tx_valid, phase, sym_ready, busy);
    end
    sb.delete();
    run_len    = 0;
    prev_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: tx_valid=%0b busy=%0b expected 0 0", tx_valid, busy);
    end
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    test_reset_state();
    rst_n = 1'b1;
    tick();
    test_single();
    wait_idle();
    test_back_to_back();
    test_flow_control();
    test_simultaneous();
`ifdef SYMTX_PREAMBLE_EN
    test_preamble();
    wait_idle();
`endif
    test_reset();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d samples never produced, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/symbol_tx_scheduler.md
Name: symbol_tx_scheduler

Overview:
- Sequences the four 16-sample symbol waveform ROMs of the baseband modulator.
- Accepts 2-bit data symbols over a valid/ready handshake and buffers them in a small FIFO.
- Drives the shared ROM phase address and waveform select, and registers the selected sample onto the TX output stream.
- Sits between the bit-to-symbol mapper and the DAC/filter stage; back-to-back symbols are gapless.

Parameters:
- SAMPLES_PER_SYM, 16, samples per symbol; the phase counter wraps at this value (power of 2, max 16).
- FIFO_DEPTH, 4, input symbol FIFO entries (power of 2, >=2).
- PREAMBLE_LEN, 4, preamble symbols; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sym_valid  in  1  mapper offers a symbol.
- sym_data  in  2  symbol index 0..3.
- sym_ready  out  1  FIFO can accept a symbol.
- sample_in0  in  10 signed  waveform ROM 0 sample at address phase.
- sample_in1  in  10 signed  waveform ROM 1 sample at address phase.
- sample_in2  in  10 signed  waveform ROM 2 sample at address phase.
- sample_in3  in  10 signed  waveform ROM 3 sample at address phase.
- phase  out  4  shared ROM address; ROMs read combinationally.
- sym_sel  out  2  symbol currently being transmitted.
- tx_out  out  10 signed  registered output sample.
- tx_valid  out  1  tx_out holds a valid sample.
- busy  out  1  state != IDLE or FIFO not empty.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; FIFO emptied, contents discarded.
  - phase=0, sym_sel=0, tx_out=0, tx_valid=0, busy=0; sym_ready=1 once out of reset.
  - Asserting reset mid-symbol aborts immediately; no partial symbol resumes.
- FIFO:
  - Push when sym_valid && sym_ready.
  - sym_ready = (count != FIFO_DEPTH), combinational from registered count.
  - Full with pop in the same cycle: ready stays 0; no push.
  - Push and pop in the same cycle: count unchanged.
  - No bypass: a pushed entry can be popped from the next edge onward.
- States IDLE, RUN (plus PRE with the option).
- IDLE:
  - tx_valid=0, tx_out=0, phase=0.
  - If count>0: pop into sym_sel, phase=0, go RUN.
- RUN:
  - Each edge: tx_out <= sample_in[sym_sel] (the sample at the current phase), tx_valid <= 1, phase <= phase+1.
  - At phase==SAMPLES_PER_SYM-1 with count>0: pop next symbol into sym_sel, phase wraps to 0 (gapless).
  - At phase==SAMPLES_PER_SYM-1 with count==0: go IDLE after emitting this sample.
- Latency:
  - Symbol accepted at edge t; popped at edge t+1; first sample registered at edge t+2.
  - tx_valid rises after edge t+2 and falls one cycle after the last sample of the final symbol.
- Width: samples pass through unmodified; no arithmetic on the datapath.

Optional Feature:
- Macro: SYMTX_PREAMBLE_EN.
- With the macro defined:
  - On IDLE->start, the block enters PRE and transmits PREAMBLE_LEN symbols alternating 0,3,0,3..., then pops FIFO data with no gap.
  - The FIFO is not popped during PRE; sym_sel shows the preamble symbol.
  - Preamble restarts after every return to IDLE.
- Without the macro: the PRE state is absent and IDLE pops data directly.

Test Plan:
- Reset behaviour: drive rst_n=0 mid-RUN at phase 7 -> tx_out=0, tx_valid=0, phase=0, sym_ready=1 immediately, regardless of clk. After release with no input, the block stays IDLE.
- Single symbol: ROM models hold the cos table (ROM2: 100,54,0,-54,-100,-131,-141,...). Push sym_data=2 at edge t -> tx_out=100 after t+2, -100 after t+6, -141 after t+8, 131 after t+17, tx_valid=0 after t+18, busy=0.
- Back-to-back symbols: push 2,1,3,0 consecutively -> 64 contiguous valid samples; sym_sel changes exactly at phase wrap; no tx_valid gap.
- Flow control: push 6 symbols with no pops possible (first still in IDLE->RUN) -> sym_ready=0 when count=4; a held sym_valid completes after the first pop; no symbol is lost or duplicated.
- Simultaneous events: push at the same edge as a wrap-pop with count=1 -> count stays 1; the next symbol starts at the following wrap.
- With SYMTX_PREAMBLE_EN: push 1 -> sym_sel sequence 0,3,0,3,1, each 16 samples, gapless; then IDLE.
